// File: rtl/fir_pkg.sv
// Shared defaults and the rounding/saturation helper for the FIR MAC datapath.
package fir_pkg;

    localparam int DEF_WORD_WIDTH  = 16;
    localparam int DEF_COEFF_WIDTH = 16;
    localparam int DEF_OUT_WIDTH   = 16;

    // Working width of sat_round; callers sign-extend their accumulator into it.
    localparam int SR_W = 64;

    // Round half up, arithmetic shift right, then clip to out_width signed bits.
    // Returns {sat, y}; y occupies the low out_width bits, sign-extended.
    function automatic logic [SR_W:0] sat_round(input logic signed [SR_W-1:0] acc,
                                                input int shift,
                                                input int out_width);
        logic signed [SR_W:0] one;
        logic signed [SR_W:0] ext;
        logic signed [SR_W:0] r;
        logic signed [SR_W:0] maxv;
        logic signed [SR_W:0] minv;
        logic signed [SR_W:0] yv;
        logic                 s;
        one  = 1;
        ext  = {acc[SR_W-1], acc};
        r    = (ext + (one <<< (shift - 1))) >>> shift;
        maxv = (one <<< (out_width - 1)) - one;
        minv = -(one <<< (out_width - 1));
        if (r > maxv) begin
            yv = maxv;
            s  = 1'b1;
        end else if (r < minv) begin
            yv = minv;
            s  = 1'b1;
        end else begin
            yv = r;
            s  = 1'b0;
        end
        return {s, yv[SR_W-1:0]};
    endfunction

endpackage

// File: rtl/round_sat.sv
// Combinational Qn rounding and signed saturation of an accumulator to the output width.
module round_sat
    import fir_pkg::*;
#(
    parameter int ACC_WIDTH  = 36,
    parameter int FRAC_SHIFT = 15,
    parameter int OUT_WIDTH  = 16
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] y,
    output logic                        sat
);

    logic [SR_W:0] res;
    logic          unused_hi;

    always_comb begin
        res = sat_round(SR_W'(acc), FRAC_SHIFT, OUT_WIDTH);
        y   = res[OUT_WIDTH-1:0];
        sat = res[SR_W];
    end

    // Upper bits are just the sign extension of y.
    assign unused_hi = ^res[SR_W-1:OUT_WIDTH];

endmodule

// File: rtl/fir_mac_pipe.sv
// Three-stage signed MAC: register tap, multiply, accumulate frame and emit rounded result.
module fir_mac_pipe
    import fir_pkg::*;
#(
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int GUARD_BITS  = 4,
    parameter int FRAC_SHIFT  = 15,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [WORD_WIDTH-1:0]  d,
    input  logic signed [COEFF_WIDTH-1:0] coeff,
    input  logic                          first,
    input  logic                          last,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   y,
    output logic                          sat
);

    localparam int PROD_WIDTH = WORD_WIDTH + COEFF_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + GUARD_BITS;

    logic                          vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
    logic signed [WORD_WIDTH-1:0]  d_p1_q, d_p1_d;
    logic signed [COEFF_WIDTH-1:0] coeff_p1_q, coeff_p1_d;
    logic                          vld_p2_q, vld_p2_d, first_p2_q, first_p2_d, last_p2_q, last_p2_d;
    logic signed [PROD_WIDTH-1:0]  prod_p2_q, prod_p2_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          out_valid_q, out_valid_d, sat_q, sat_d;
    logic signed [OUT_WIDTH-1:0]   y_q, y_d;
    logic signed [OUT_WIDTH-1:0]   rs_y;
    logic                          rs_sat;

    round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .acc(acc_d),
        .y  (rs_y),
        .sat(rs_sat)
    );

    always_comb begin
        // Stage 1: capture the tap; markers only count on valid beats.
        vld_p1_d   = in_valid;
        first_p1_d = in_valid & first;
        last_p1_d  = in_valid & last;
        d_p1_d     = d;
        coeff_p1_d = coeff;

        // Stage 2: exact full-width product.
        vld_p2_d   = vld_p1_q;
        first_p2_d = first_p1_q;
        last_p2_d  = last_p1_q;
        prod_p2_d  = PROD_WIDTH'(d_p1_q) * PROD_WIDTH'(coeff_p1_q);

        // Stage 3: accumulate, and on the last tap round the updated sum directly.
        acc_d = acc_q;
        if (vld_p2_q) begin
            acc_d = first_p2_q ? ACC_WIDTH'(prod_p2_q) : acc_q + ACC_WIDTH'(prod_p2_q);
        end
        out_valid_d = vld_p2_q & last_p2_q;
        y_d         = y_q;
        sat_d       = sat_q;
        if (out_valid_d) begin
            y_d   = rs_y;
            sat_d = rs_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q    <= 1'b0;
            first_p1_q  <= 1'b0;
            last_p1_q   <= 1'b0;
            vld_p2_q    <= 1'b0;
            first_p2_q  <= 1'b0;
            last_p2_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            first_p1_q  <= first_p1_d;
            last_p1_q   <= last_p1_d;
            vld_p2_q    <= vld_p2_d;
            first_p2_q  <= first_p2_d;
            last_p2_q   <= last_p2_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            sat_q       <= sat_d;
        end
    end

    // Pure data registers; their contents are ignored whenever the paired valid is low.
    always_ff @(posedge clk) begin
        d_p1_q     <= d_p1_d;
        coeff_p1_q <= coeff_p1_d;
        prod_p2_q  <= prod_p2_d;
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_mac_pipe.sv
// Scoreboard bench for fir_mac_pipe: directed taps push expected results, a monitor pops on out_valid.
module tb_fir_mac_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] d;
    logic signed [15:0] coeff;
    logic               first;
    logic               last;
    logic               out_valid;
    logic signed [15:0] y;
    logic               sat;

    typedef struct {
        logic signed [15:0] y;
        logic               sat;
        int                 cyc;
        string              name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    fir_mac_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .d        (d),
        .coeff    (coeff),
        .first    (first),
        .last     (last),
        .out_valid(out_valid),
        .y        (y),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid !== 1'b0 && reset === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got out_valid=%b y=%0d with nothing expected",
                         out_valid, y);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_y"}, y, mon_e.y);
                check({mon_e.name, "_sat"}, sat, mon_e.sat);
                check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    // Issue one tap; called just after a falling edge, returns after the next one.
    task automatic tap(input logic signed [15:0] dv, input logic signed [15:0] cv,
                       input logic f, input logic l, input logic expect_out,
                       input logic signed [15:0] ey, input logic es, input string nm);
        exp_t e;
        in_valid = 1'b1;
        d        = dv;
        coeff    = cv;
        first    = f;
        last     = l;
        if (expect_out) begin
            e.y    = ey;
            e.sat  = es;
            e.cyc  = cyc + 3;
            e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        first    = 1'b0;
        last     = 1'b0;
        d        = 16'sd7;
        coeff    = 16'sd7;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int waited;
        reset    = 1'b1;
        in_valid = 1'b0;
        d        = '0;
        coeff    = '0;
        first    = 1'b0;
        last     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_y", y, 0);
        check("reset_sat", sat, 0);
        reset = 1'b0;
        @(negedge clk);

        tap(16'sd16384, 16'sd16384, 1, 1, 1, 16'sd8192, 0, "single_tap");
        tap(16'sd1, 16'sd16384, 1, 1, 1, 16'sd1, 0, "round_up");
        tap(16'sd1, 16'sd16383, 1, 1, 1, 16'sd0, 0, "round_down");

        tap(-16'sd32768, -16'sd32768, 1, 0, 0, 0, 0, "");
        tap(-16'sd32768, -16'sd32768, 0, 0, 0, 0, 0, "");
        tap(-16'sd32768, -16'sd32768, 0, 0, 0, 0, 0, "");
        tap(-16'sd32768, -16'sd32768, 0, 1, 1, 16'sd32767, 1, "pos_sat");

        tap(-16'sd32768, 16'sd32767, 1, 0, 0, 0, 0, "");
        tap(-16'sd32768, 16'sd32767, 0, 1, 1, -16'sd32768, 1, "neg_sat");

        // An unterminated partial frame is dropped by the next first.
        tap(16'sd5000, 16'sd16384, 1, 0, 0, 0, 0, "");
        tap(16'sd2, 16'sd16384, 1, 1, 1, 16'sd1, 0, "restart");

        tap(16'sd1000, 16'sd16384, 1, 0, 0, 0, 0, "");
        idle(1);
        tap(16'sd1000, 16'sd16384, 0, 1, 1, 16'sd1000, 0, "frame_a");
        tap(-16'sd1000, 16'sd16384, 1, 1, 1, -16'sd500, 0, "frame_b");
        idle(5);

        // Reset while a complete frame is still in flight must swallow it.
        tap(16'sd100, 16'sd16384, 1, 0, 0, 0, 0, "");
        tap(16'sd100, 16'sd16384, 0, 1, 0, 0, 0, "");
        idle(0);
        reset = 1'b1;
        @(negedge clk);
        check("during_reset_out_valid", out_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_out_valid", out_valid, 0);
        check("after_reset_y", y, 0);
        tap(16'sd20, 16'sd32767, 1, 1, 1, 16'sd20, 0, "post_reset");
        idle(1);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain_outstanding", sb.size(), 0);

        idle(3);
        check("hold_out_valid", out_valid, 0);
        check("hold_y", y, 20);
        check("hold_sat", sat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
